// File: rtl/tt_probe_streamer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_probe_streamer_if : valid/ready byte-stream port of the probe streamer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface tt_probe_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/tt_probe_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tt_probe_streamer : snapshots probe channels, emits SYNC/SEQ/DATA/CSUM     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tt_probe_streamer #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     ena,
  input  wire [NUM_CH*CH_W-1:0]   probe_in,
  input  wire                     trig,
  input  wire                     cont,
  input  wire                     clr_drop,
  tt_probe_streamer_if.master     out_if,
  output logic                    busy,
  output logic                    dropped,
  output logic [7:0]              drop_cnt
);

  localparam int BPC       = CH_W / 8;
  localparam int NBYTES    = NUM_CH * BPC;
  localparam int IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SNAP_W    = NUM_CH * CH_W;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_SEQ  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  state_t             state_q;
  logic [SNAP_W-1:0]  snap_q;
  logic [7:0]         seq_q;
  logic [7:0]         csum_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         out_data_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               dropped_q;
  logic [7:0]         drop_cnt_q;

  logic               start_d;
  logic               xfer_d;
  logic               csum_acc_d;
  logic               drop_d;
  logic               last_d;
  logic [IDX_W-1:0]   idx_nxt_d;
  logic [SNAP_W-1:0]  snap_shift_d;
  logic [7:0]         byte_nxt_d;

  assign start_d      = (trig | cont) & ena;
  assign xfer_d       = out_valid_q & out_if.out_ready;
  assign csum_acc_d   = (state_q == ST_CSUM) & xfer_d;
  // The CSUM-accept edge is where a new frame may start, so trig there is not a drop.
  assign drop_d       = trig & busy_q & ~csum_acc_d;
  assign last_d       = (idx_q == IDX_W'(NBYTES - 1));
  assign idx_nxt_d    = idx_q + IDX_W'(1);
  assign snap_shift_d = snap_q >> {idx_nxt_d, 3'b000};
  assign byte_nxt_d   = snap_shift_d[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      seq_q       <= 8'd0;
      csum_q      <= 8'd0;
      idx_q       <= '0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      if (clr_drop) begin
        dropped_q  <= 1'b0;
        drop_cnt_q <= 8'd0;
      end else if (drop_d) begin
        dropped_q  <= 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_q <= drop_cnt_q + 8'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            snap_q      <= probe_in;
            csum_q      <= 8'd0;
            out_data_q  <= SYNC_BYTE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (xfer_d) begin
            csum_q     <= csum_q ^ out_data_q;
            out_data_q <= seq_q;
            state_q    <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (xfer_d) begin
            csum_q     <= csum_q ^ out_data_q;
            out_data_q <= snap_q[7:0];
            idx_q      <= '0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer_d) begin
            csum_q <= csum_q ^ out_data_q;
            if (last_d) begin
              out_data_q <= csum_q ^ out_data_q;
              state_q    <= ST_CSUM;
            end else begin
              idx_q      <= idx_nxt_d;
              out_data_q <= byte_nxt_d;
            end
          end
        end
        ST_CSUM: begin
          if (xfer_d) begin
            seq_q <= seq_q + 8'd1;
            if (start_d) begin
              snap_q     <= probe_in;
              csum_q     <= 8'd0;
              out_data_q <= SYNC_BYTE;
              state_q    <= ST_SYNC;
            end else begin
              out_data_q  <= 8'd0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign busy             = busy_q;
  assign dropped          = dropped_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire
